// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared memory port.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        stall_req;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, stall_req
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, stall_req
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, one
// transaction at a time, with data priority bounded by a fetch starvation guard.
module mem_port_arbiter #(
  parameter int MEM_LAT     = 2,
  parameter int MAX_IF_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STARVE_W = $clog2(MAX_IF_WAIT + 1);
  localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_IF_WAIT);

  state_t              state;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                owner_d;

  logic        mem_ce_r;
  logic        mem_we_r;
  logic [3:0]  mem_sel_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        if_rvalid_r;
  logic [31:0] if_rdata_r;
  logic        d_rvalid_r;
  logic [31:0] d_rdata_r;

  logic if_win;
  logic d_win;

  // Data wins a tie unless fetch has already been passed over MAX_IF_WAIT times.
  always_comb begin
    // NOTE: both grants get a default first so no path through this block infers a latch.
    if_win = 1'b0;
    d_win  = 1'b0;
    if (rst && state == IDLE) begin
      if (bus.d_req && !(bus.if_req && starve_cnt == STARVE_MAX)) begin
        d_win = 1'b1;
      end else if (bus.if_req) begin
        if_win = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: rst is sampled only at the clock edge, so it lives inside the clocked block, not the sensitivity list.
    if (!rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      owner_d     <= 1'b0;
      mem_ce_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_sel_r   <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= '0;
      d_rvalid_r  <= 1'b0;
      d_rdata_r   <= '0;
    end else begin
      // NOTE: every register here uses <= so each one sees the pre-edge value of the others.
      unique case (state)
        IDLE: begin
          if (!bus.if_req || if_win) begin
            starve_cnt <= '0;
          end else if (d_win && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
          end
          if (d_win || if_win) begin
            owner_d     <= d_win;
            lat_cnt     <= '0;
            mem_ce_r    <= 1'b1;
            mem_we_r    <= d_win & bus.d_we;
            mem_sel_r   <= d_win ? bus.d_sel   : 4'b1111;
            mem_addr_r  <= d_win ? bus.d_addr  : bus.if_addr;
            mem_wdata_r <= d_win ? bus.d_wdata : 32'h0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (lat_cnt == LAT_LAST) begin
            mem_ce_r <= 1'b0;
            mem_we_r <= 1'b0;
            if (owner_d) begin
              d_rvalid_r <= 1'b1;
              d_rdata_r  <= mem_we_r ? 32'h0 : bus.mem_rdata;
            end else begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= bus.mem_rdata;
            end
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        RESP: begin
          if_rvalid_r <= 1'b0;
          d_rvalid_r  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rvalid  = d_rvalid_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.mem_ce    = mem_ce_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_sel   = mem_sel_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  // Stall drops in the completion cycle so the pipeline advances with the returned data.
  assign bus.stall_req = rst & ((bus.if_req & ~if_rvalid_r) | (bus.d_req & ~d_rvalid_r));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-scenario tasks with inline checks plus a
// response scoreboard, against a latency-aware single-port memory model.
module tb_mem_port_arbiter;

  localparam int LAT     = 2;
  localparam int MAX_IFW = 4;

  typedef struct {
    logic        is_data;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_LAT(LAT), .MAX_IF_WAIT(MAX_IFW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory model: read data is only valid once mem_ce has been held LAT cycles.
  logic [31:0] mem_arr [0:255];
  int          ce_cnt;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      ce_cnt <= 0;
      for (int i = 0; i < 256; i++) mem_arr[i] <= (i == 1) ? 32'h3401_FFFF : init_word(i);
    end else if (bus.mem_ce) begin
      if (ce_cnt == LAT - 1 && bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_sel[b]) mem_arr[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      ce_cnt <= ce_cnt + 1;
    end else begin
      ce_cnt <= 0;
    end
  end

  assign bus.mem_rdata = (bus.mem_ce && ce_cnt == LAT - 1) ? mem_arr[bus.mem_addr[9:2]] : 32'hBAD0_BAD0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t        e;
    logic [31:0] got_data;
    forever begin
      @(negedge clk);
      if (bus.if_rvalid || bus.d_rvalid) begin
        total++;
        if (bus.if_rvalid && bus.d_rvalid) begin
          bad++;
          $display("FAIL rvalid_both: got if=1 d=1 want only one");
        end else if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rvalid: got d_rvalid=%b if_rvalid=%b want none", bus.d_rvalid, bus.if_rvalid);
        end else begin
          e = sb_q.pop_front();
          got_data = bus.d_rvalid ? bus.d_rdata : bus.if_rdata;
          if (bus.d_rvalid !== e.is_data || got_data !== e.data) begin
            bad++;
            $display("FAIL response: got is_data=%b data=%h want is_data=%b data=%h",
                     bus.d_rvalid, got_data, e.is_data, e.data);
          end
        end
      end
    end
  endtask

  task automatic do_txn(input logic is_data, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input string name);
    exp_t        e;
    logic [1:0]  got2;
    logic [1:0]  exp2;
    logic [37:0] got_mem;
    logic [37:0] exp_mem;
    if (is_data) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_sel = sel; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    e.is_data = is_data;
    e.data    = (is_data && we) ? 32'h0 : exp_data;
    sb_q.push_back(e);
    #1;
    got2 = {bus.d_gnt, bus.if_gnt}; exp2 = {is_data, ~is_data};
    total++;
    if (got2 !== exp2 || bus.stall_req !== 1'b1) begin
      bad++;
      $display("FAIL %s_grant: got gnt(d,if)=%b stall=%b want %b stall=1", name, got2, bus.stall_req, exp2);
    end
    next_cycle();
    for (int k = 1; k <= LAT; k++) begin
      got_mem = {bus.mem_ce, bus.mem_we, bus.mem_sel, bus.mem_addr};
      exp_mem = {1'b1, is_data & we, is_data ? sel : 4'hF, addr};
      total++;
      if (got_mem !== exp_mem || bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL %s_busy%0d: got ce/we/sel/addr=%h rv=%b%b want %h rv=00",
                 name, k, got_mem, bus.d_rvalid, bus.if_rvalid, exp_mem);
      end
      if (is_data && we) begin
        total++;
        if (bus.mem_wdata !== wdata) begin
          bad++;
          $display("FAIL %s_wdata%0d: got %h want %h", name, k, bus.mem_wdata, wdata);
        end
      end
      next_cycle();
    end
    got2 = {bus.d_rvalid, bus.if_rvalid};
    total++;
    if (got2 !== exp2 || bus.mem_ce !== 1'b0 || bus.mem_we !== 1'b0 || bus.stall_req !== 1'b0) begin
      bad++;
      $display("FAIL %s_resp: got rv(d,if)=%b ce=%b we=%b stall=%b want %b ce=0 we=0 stall=0",
               name, got2, bus.mem_ce, bus.mem_we, bus.stall_req, exp2);
    end
    next_cycle();
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    #1;
    total++;
    if ({bus.d_rvalid, bus.if_rvalid, bus.d_gnt, bus.if_gnt, bus.mem_ce, bus.stall_req} !== 6'b0) begin
      bad++;
      $display("FAIL %s_idle: got rv=%b%b gnt=%b%b ce=%b stall=%b want all 0", name,
               bus.d_rvalid, bus.if_rvalid, bus.d_gnt, bus.if_gnt, bus.mem_ce, bus.stall_req);
    end
    next_cycle();
  endtask

  // Both requesters raise req together in cycle 0: data first, then fetch.
  task automatic run_both(input string name);
    exp_t       e;
    logic [4:0] got5;
    logic [4:0] exp5;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_sel = 4'hF; bus.d_addr = 32'h40;
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    e.is_data = 1'b1; e.data = init_word(16);   sb_q.push_back(e);
    e.is_data = 1'b0; e.data = 32'h3401_FFFF;   sb_q.push_back(e);
    for (int c = 0; c <= 2*LAT + 4; c++) begin
      if (c == LAT + 2)   bus.d_req  = 1'b0;
      if (c == 2*LAT + 4) bus.if_req = 1'b0;
      #1;
      got5 = {bus.d_gnt, bus.if_gnt, bus.d_rvalid, bus.if_rvalid, bus.stall_req};
      exp5 = {c == 0, c == LAT + 2, c == LAT + 1, c == 2*LAT + 3, c <= 2*LAT + 2};
      total++;
      if (got5 !== exp5) begin
        bad++;
        $display("FAIL %s_c%0d: got dgnt/ifgnt/drv/ifrv/stall=%b want %b", name, c, got5, exp5);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    bus.d_we = 1'b0; bus.d_sel = 4'hF; bus.d_addr = 32'h40; bus.d_wdata = 32'h0; bus.if_addr = 32'h4;
    next_cycle();
    for (int r = 0; r < 3; r++) begin
      #1;
      total++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_ce, bus.mem_we, bus.if_rvalid, bus.d_rvalid, bus.stall_req} !== 7'b0) begin
        bad++;
        $display("FAIL reset_c%0d: got gnt=%b%b ce=%b we=%b rv=%b%b stall=%b want all 0", r,
                 bus.if_gnt, bus.d_gnt, bus.mem_ce, bus.mem_we, bus.if_rvalid, bus.d_rvalid, bus.stall_req);
      end
      next_cycle();
    end
    rst = 1'b1;
    run_both("reset_release");
  endtask

  task automatic test_fetch();
    do_txn(1'b0, 1'b0, 4'h0, 32'h4, 32'h0, 32'h3401_FFFF, "fetch");
  endtask

  task automatic test_write();
    do_txn(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 32'h0, "write");
    do_txn(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, "readback");
  endtask

  task automatic test_both();
    run_both("both");
  endtask

  task automatic test_starve();
    exp_t e;
    int   grants = 0;
    int   last_c = -1;
    bit   done   = 1'b0;
    logic exp_d;
    bus.d_we = 1'b0; bus.d_sel = 4'hF; bus.d_addr = 32'h200; bus.if_addr = 32'h8;
    bus.d_req = 1'b1; bus.if_req = 1'b1;
    for (int k = 0; k < MAX_IFW + 2; k++) begin
      e.is_data = (k != MAX_IFW);
      e.data    = e.is_data ? init_word(128) : init_word(2);
      sb_q.push_back(e);
    end
    for (int c = 0; c < 200 && !done; c++) begin
      if (grants == MAX_IFW + 2 && c == last_c + LAT + 2) begin
        bus.d_req = 1'b0; bus.if_req = 1'b0; done = 1'b1;
      end
      #1;
      if (bus.d_gnt || bus.if_gnt) begin
        exp_d = (grants != MAX_IFW);
        total++;
        if (bus.d_gnt !== exp_d || bus.if_gnt !== !exp_d) begin
          bad++;
          $display("FAIL starve_grant%0d: got d_gnt=%b if_gnt=%b want d_gnt=%b if_gnt=%b",
                   grants, bus.d_gnt, bus.if_gnt, exp_d, !exp_d);
        end
        grants++;
        last_c = c;
      end
      next_cycle();
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL starve_budget: got %0d grants want %0d within 200 cycles", grants, MAX_IFW + 2);
    end
  endtask

  task automatic test_reset_busy();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    #1;
    total++;
    if (bus.if_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rbusy_grant: got if_gnt=%b want 1", bus.if_gnt);
    end
    next_cycle();
    total++;
    if (bus.mem_ce !== 1'b1) begin
      bad++;
      $display("FAIL rbusy_ce: got mem_ce=%b want 1", bus.mem_ce);
    end
    rst = 1'b0;
    next_cycle();
    total++;
    if ({bus.mem_ce, bus.if_rvalid, bus.if_gnt, bus.stall_req} !== 4'b0) begin
      bad++;
      $display("FAIL rbusy_abort: got ce=%b ifrv=%b ifgnt=%b stall=%b want all 0",
               bus.mem_ce, bus.if_rvalid, bus.if_gnt, bus.stall_req);
    end
    bus.if_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    do_txn(1'b0, 1'b0, 4'h0, 32'hC, 32'h0, init_word(3), "refetch");
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_sel = '0; bus.d_addr = '0; bus.d_wdata = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_fetch();
    test_write();
    test_both();
    test_starve();
    test_reset_busy();
    for (int i = 0; i < 3; i++) next_cycle();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending responses want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch stage and the data-access (MEM) stage of the openmips core inside the minimal SOPC.
- Accepts one transaction at a time. Data accesses take priority, and a starvation guard protects instruction fetch.
- Returns read data with a one-cycle valid pulse.
- Drives a stall request to the pipeline control unit while any request is outstanding.

Parameters:
- MEM_LAT, 2, number of cycles the memory needs mem_ce held before mem_rdata is valid (>=1)
- MAX_IF_WAIT, 4, max consecutive data grants allowed while if_req is pending (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
- if_req  in  1  fetch request; held until if_rvalid
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held until d_rvalid
- d_we  in  1  1=write, 0=read
- d_sel  in  4  byte enables
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle completion pulse (reads and writes)
- d_rdata  out  32  read data; 0 for writes
- mem_ce  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_sel  out  4  byte enables to memory
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- stall_req  out  1  pipeline stall request

Behaviour:
- Reset:
  - rst==0 at any edge forces state IDLE and clears all registered outputs, the latency counter and the starve counter.
  - Any in-flight transaction is abandoned and no rvalid is issued for it.
  - Held during reset, all outputs read 0, including gnt and stall_req.
- FSM states IDLE, BUSY, RESP:
  - IDLE: arbitrate.
    - if_gnt/d_gnt are combinational and asserted only in IDLE while rst==1.
    - The selected requester's fields are captured at that edge, then the FSM goes to BUSY.
    - With no request, the FSM stays in IDLE.
  - BUSY: lasts exactly MEM_LAT cycles.
    - mem_ce=1; mem_we = captured d_we (0 for fetch).
    - mem_sel/addr/wdata are held from the captured values; mem_sel=4'b1111 for fetch.
    - At the edge ending the last BUSY cycle, mem_rdata is captured. For a data write, d_rdata is set to 0 instead.
    - Next state is RESP.
  - RESP: one cycle.
    - mem_ce=0 and mem_we=0.
    - The owner's rvalid is 1 and its rdata is valid; next state is IDLE.
- Latency: gnt in cycle T, mem_ce high T+1..T+MEM_LAT, rvalid in T+MEM_LAT+1. Throughput is one transaction per MEM_LAT+2 cycles.
- Requester rule: a requester sees rvalid at T+MEM_LAT+1. It must present its next decision on req at the following edge; req high in IDLE is a new request.
- Arbitration when both req are high in IDLE:
  - Data wins, unless starve_cnt==MAX_IF_WAIT, in which case fetch wins.
  - starve_cnt increments on each data grant made while if_req=1 (saturates at MAX_IF_WAIT).
  - starve_cnt clears on a fetch grant, or in IDLE when if_req=0.
- Single requester: it is granted immediately in IDLE regardless of starve_cnt.
- stall_req = (if_req & ~if_rvalid) | (d_req & ~d_rvalid). It is combinational and forced to 0 during reset.
- Idle outputs: if_rdata and d_rdata hold their last values until overwritten; rvalid is asserted only in RESP.
- No simultaneous grants: at most one of if_gnt/d_gnt is high in any cycle.

Test Plan:
1. rst=0 for 3 cycles with if_req=d_req=1 -> if_gnt, d_gnt, mem_ce, rvalids and stall_req all 0; first grant (d_gnt) in the first cycle after release.
2. MEM_LAT=2, if_req alone, if_addr=0x00000004, mem_rdata=0x3401FFFF -> if_gnt cycle 0; mem_ce=1 and mem_addr=0x4 cycles 1-2; if_rvalid=1 with if_rdata=0x3401FFFF in cycle 3; IDLE in cycle 4.
3. Data write d_we=1, d_sel=4'b1111, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=1 cycles 1-2 with matching addr/wdata; d_rvalid cycle 3 with d_rdata=0.
4. if_req and d_req rise together at cycle 0 -> d_gnt cycle 0, d_rvalid cycle 3, if_gnt cycle 4, if_rvalid cycle 7; stall_req high cycles 0-6.
5. MAX_IF_WAIT=4, d_req and if_req held high continuously -> exactly 4 consecutive d_gnt, then if_gnt on the 5th grant, then data grants resume.
6. rst=0 during the first BUSY cycle of a fetch -> next cycle mem_ce=0 and no if_rvalid; after release, the re-asserted fetch completes in MEM_LAT+2 cycles with correct data.
